ddr3_init_sequencer: RTL and testbench

- Wishbone classic master that runs the DDR3 power-up and mode-register sequence through the DFII CSR bank, then hands the PHY to hardware control.
- Sits between the SoC reset/boot logic and the DRAM controller CSR bus, and replaces a software or bench-driven init.
- One start pulse runs the whole fixed write/wait script, then reports done or error.

---
 rtl/ddr3_init_sequencer.sv | 245 ++++++++++++++++++++++++
 tb/tb_ddr3_init_sequencer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_init_sequencer.sv
// rtl/ddr3_init_sequencer.sv - DDR3 power-up and mode-register init sequencer driving the DFII CSR bank over Wishbone
//
// Purpose: on a start pulse, walk a fixed 32-entry script of CSR writes and idle
// delays, then hand the PHY to hardware control and report done (or error on an
// ack timeout).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start                    pulse; accepted in IDLE, DONE or ERROR only
//   busy, done, error        status; done/error held until start or rst
//   step                     current script index (debug)
//   wb_adr/wb_dat_w/wb_sel   Wishbone classic master write address/data/selects
//   wb_cyc/wb_stb/wb_we      Wishbone cycle, strobe (== cyc), write enable
//   wb_dat_r, wb_ack         Wishbone read data (unused) and acknowledge
module ddr3_init_sequencer #(
    parameter logic [29:0] CSR_BASE     = 30'h2400,
    parameter int          WAIT_DLLK    = 600,
    parameter int          WAIT_ZQ      = 600,
    parameter int          WAIT_HANDOFF = 200,
    parameter int          ACK_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [5:0]  step,
    output logic [29:0] wb_adr,
    output logic [31:0] wb_dat_w,
    input  logic [31:0] wb_dat_r,
    output logic [3:0]  wb_sel,
    output logic        wb_cyc,
    output logic        wb_stb,
    output logic        wb_we,
    input  logic        wb_ack
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_BUS, S_DELAY, S_DONE, S_ERROR} state_t;

    typedef struct packed {
        logic        is_end;
        logic        is_delay;
        logic [2:0]  offset;
        logic [31:0] data;
        logic [15:0] count;
    } entry_t;

    localparam logic [2:0] REG_CONTROL  = 3'd0;
    localparam logic [2:0] REG_COMMAND  = 3'd1;
    localparam logic [2:0] REG_ISSUE    = 3'd2;
    localparam logic [2:0] REG_ADDRESS  = 3'd3;
    localparam logic [2:0] REG_BADDRESS = 3'd4;

    function automatic entry_t wr(input logic [2:0] off, input logic [31:0] data);
        return {1'b0, 1'b0, off, data, 16'd0};
    endfunction

    function automatic entry_t dly(input logic [15:0] n);
        return {1'b0, 1'b1, 3'd0, 32'd0, n};
    endfunction

    // Steps 4..23 are five MRS groups of four writes each; the group index and
    // the position within the group fall out of (idx - 4) directly.
    function automatic entry_t script(input logic [5:0] idx);
        logic [5:0]  rel;
        logic [31:0] mr_a;
        logic [31:0] mr_b;
        entry_t      e;
        rel = idx - 6'd4;
        case (rel[4:2])
            3'd0:    begin mr_a = 32'h200; mr_b = 32'd2; end
            3'd1:    begin mr_a = 32'h000; mr_b = 32'd3; end
            3'd2:    begin mr_a = 32'h006; mr_b = 32'd1; end
            3'd3:    begin mr_a = 32'h320; mr_b = 32'd0; end
            default: begin mr_a = 32'h220; mr_b = 32'd0; end
        endcase
        e = {1'b1, 1'b0, 3'd0, 32'd0, 16'd0};
        if (idx >= 6'd4 && idx <= 6'd23) begin
            case (rel[1:0])
                2'd0:    e = wr(REG_ADDRESS, mr_a);
                2'd1:    e = wr(REG_BADDRESS, mr_b);
                2'd2:    e = wr(REG_COMMAND, 32'h0F);
                default: e = wr(REG_ISSUE, 32'h01);
            endcase
        end else begin
            case (idx)
                6'd0:    e = wr(REG_ADDRESS, 32'h0);
                6'd1:    e = wr(REG_BADDRESS, 32'h0);
                6'd2:    e = wr(REG_CONTROL, 32'h0C);
                6'd3:    e = wr(REG_CONTROL, 32'h0E);
                6'd24:   e = dly(16'(WAIT_DLLK));
                6'd25:   e = wr(REG_ADDRESS, 32'h400);
                6'd26:   e = wr(REG_BADDRESS, 32'h0);
                6'd27:   e = wr(REG_COMMAND, 32'h03);
                6'd28:   e = wr(REG_ISSUE, 32'h01);
                6'd29:   e = dly(16'(WAIT_ZQ));
                6'd30:   e = wr(REG_CONTROL, 32'h01);
                6'd31:   e = dly(16'(WAIT_HANDOFF));
                default: e = {1'b1, 1'b0, 3'd0, 32'd0, 16'd0};
            endcase
        end
        return e;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  step_q, step_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] tmo_q, tmo_d;
    logic        busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic        cyc_q, cyc_d, we_q, we_d;
    logic [3:0]  sel_q, sel_d;
    logic [29:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;

    entry_t      cur;
    logic [15:0] tmo_inc;
    logic        timeout_hit;
    logic        dat_r_unused;

    assign cur          = script(step_q);
    assign tmo_inc      = tmo_q + 16'd1;
    assign timeout_hit  = (tmo_inc == 16'(ACK_TIMEOUT));
    assign dat_r_unused = ^wb_dat_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            error_q <= error_d;
            cyc_q   <= cyc_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
        end
    end

    // A delay of n leaves the bus idle for n+1 cycles in total: the LOAD cycle
    // of the delay step, n-1 DELAY cycles, and the LOAD cycle of the next write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: if (start) state_d = S_LOAD;
            S_LOAD: begin
                if (cur.is_end)                             state_d = S_DONE;
                else if (cur.is_delay && cur.count > 16'd1) state_d = S_DELAY;
                else if (!cur.is_delay)                     state_d = S_BUS;
            end
            S_BUS: begin
                if (wb_ack)           state_d = S_LOAD;
                else if (timeout_hit) state_d = S_ERROR;
            end
            S_DELAY: if (cnt_q <= 16'd2) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        step_d  = step_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        busy_d  = busy_q;
        done_d  = done_q;
        error_d = error_q;
        cyc_d   = cyc_q;
        we_d    = we_q;
        sel_d   = sel_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    step_d  = '0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_LOAD: begin
                if (cur.is_end) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else if (cur.is_delay) begin
                    cnt_d = cur.count;
                    if (cur.count <= 16'd1) step_d = step_q + 6'd1;
                end else begin
                    adr_d = CSR_BASE + 30'(cur.offset);
                    dat_d = cur.data;
                    cyc_d = 1'b1;
                    we_d  = 1'b1;
                    sel_d = 4'hF;
                    tmo_d = '0;
                end
            end
            S_BUS: begin
                if (wb_ack) begin
                    cyc_d  = 1'b0;
                    we_d   = 1'b0;
                    sel_d  = '0;
                    step_d = step_q + 6'd1;
                end else if (timeout_hit) begin
                    cyc_d   = 1'b0;
                    we_d    = 1'b0;
                    sel_d   = '0;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    tmo_d = tmo_inc;
                end
            end
            S_DELAY: begin
                cnt_d = cnt_q - 16'd1;
                if (cnt_q <= 16'd2) step_d = step_q + 6'd1;
            end
            default: ;
        endcase
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign step     = step_q;
    assign wb_adr   = adr_q;
    assign wb_dat_w = dat_q;
    assign wb_sel   = sel_q;
    assign wb_cyc   = cyc_q;
    assign wb_stb   = cyc_q;
    assign wb_we    = we_q;
endmodule

// File: tb/tb_ddr3_init_sequencer.sv
// tb/tb_ddr3_init_sequencer.sv - self-checking bench for ddr3_init_sequencer
module tb_ddr3_init_sequencer;
    localparam int TO     = 16;
    localparam int W_DLLK = 600;
    localparam int W_ZQ   = 600;
    localparam int W_HO   = 200;
    localparam int NW     = 29;

    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, wb_ack = 1'b0;
    logic [31:0] wb_dat_r = 32'hDEADBEEF;
    logic        busy, done, error, wb_cyc, wb_stb, wb_we;
    logic [5:0]  step;
    logic [29:0] wb_adr;
    logic [31:0] wb_dat_w;
    logic [3:0]  wb_sel;

    ddr3_init_sequencer #(.ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .step(step), .wb_adr(wb_adr), .wb_dat_w(wb_dat_w), .wb_dat_r(wb_dat_r),
        .wb_sel(wb_sel), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_ack(wb_ack)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_errors = 0, cyc_n = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    // Expected write list, built from the script description.
    logic [29:0] exp_adr [NW];
    logic [31:0] exp_dat [NW];
    int          exp_step[NW];
    int          nb = 0;

    task automatic add_w(input int off, input int dat, input int stp);
        exp_adr[nb] = 30'h2400 + 30'(off);
        exp_dat[nb] = 32'(dat);
        exp_step[nb] = stp;
        nb++;
    endtask

    task automatic build_script();
        int mra[5];
        int mrb[5];
        mra = '{'h200, 'h000, 'h006, 'h320, 'h220};
        mrb = '{2, 3, 1, 0, 0};
        add_w(3, 0, 0); add_w(4, 0, 1); add_w(0, 'h0C, 2); add_w(0, 'h0E, 3);
        for (int g = 0; g < 5; g++) begin
            add_w(3, mra[g], 4 + 4*g); add_w(4, mrb[g], 5 + 4*g);
            add_w(1, 'h0F, 6 + 4*g);   add_w(2, 1, 7 + 4*g);
        end
        add_w(3, 'h400, 25); add_w(4, 0, 26); add_w(1, 3, 27); add_w(2, 1, 28);
        add_w(0, 1, 30);
    endtask

    // Idle cycles before write k (k == NW means before done).
    function automatic int gap_before(input int k);
        if (k == 24) return W_DLLK + 1;
        if (k == 28) return W_ZQ + 1;
        if (k == NW) return W_HO + 1;
        return 1;
    endfunction

    // Model state.
    logic m_busy = 0, m_done = 0, m_err = 0, m_cyc = 0, m_fresh = 1;
    int   m_k = 0, m_tmo = 0, m_next = -1;

    // Slave state.
    int          slave_mode = 0;   // 0 zero-wait, 1 random waits, 2 stuck at stuck_idx
    int          stuck_idx = 6;
    int          s_held = 0, s_wait = 0;
    logic        s_prev_cyc = 0;
    logic [29:0] s_pend_adr;
    logic [31:0] s_pend_dat;
    logic [29:0] log_adr[$];
    logic [31:0] log_dat[$];

    always @(negedge clk) begin
        cyc_n++;
        // Model: rst/start/ack here are the values the DUT saw at the last edge.
        if (rst) begin
            m_busy = 0; m_done = 0; m_err = 0; m_cyc = 0; m_fresh = 1;
            m_k = 0; m_tmo = 0; m_next = -1;
        end else if (start && !m_busy) begin
            m_busy = 1; m_done = 0; m_err = 0; m_cyc = 0; m_fresh = 0;
            m_k = 0; m_next = cyc_n + 1;
        end else if (m_busy) begin
            if (m_cyc) begin
                if (wb_ack) begin
                    m_cyc = 0; m_k++; m_next = cyc_n + gap_before(m_k);
                end else begin
                    m_tmo++;
                    if (m_tmo == TO) begin m_cyc = 0; m_busy = 0; m_err = 1; end
                end
            end else if (cyc_n == m_next) begin
                if (m_k == NW) begin m_busy = 0; m_done = 1; end
                else begin m_cyc = 1; m_tmo = 0; end
            end
        end

        chk("cyc", wb_cyc, m_cyc);
        chk("stb_eq_cyc", wb_stb, wb_cyc);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("error", error, m_err);
        if (m_cyc) begin
            chk("adr", wb_adr, exp_adr[m_k]);
            chk("dat_w", wb_dat_w, exp_dat[m_k]);
            chk("we", wb_we, 1);
            chk("sel", wb_sel, 4'hF);
            chk("step", step, exp_step[m_k]);
        end else begin
            chk("we_idle", wb_we, 0);
            chk("sel_idle", wb_sel, 0);
        end
        if (m_err) chk("step_err", step, exp_step[m_k]);
        if (m_fresh) begin
            chk("step_rst", step, 0);
            chk("adr_rst", wb_adr, 0);
            chk("dat_rst", wb_dat_w, 0);
        end

        // Slave: log completed writes, then drive ack for the next edge.
        if (s_prev_cyc && wb_ack && !rst) begin
            log_adr.push_back(s_pend_adr);
            log_dat.push_back(s_pend_dat);
        end
        s_prev_cyc = wb_cyc;
        if (!wb_cyc) begin
            s_held = 0;
            wb_ack = (slave_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
            s_held++;
            if (s_held == 1) s_wait = (slave_mode == 1) ? int'($urandom_range(0, 7)) : 0;
            if (slave_mode == 2 && log_adr.size() == stuck_idx) wb_ack = 1'b0;
            else wb_ack = (s_held >= s_wait + 2);
            s_pend_adr = wb_adr;
            s_pend_dat = wb_dat_w;
        end
    end

    int          g_gap[30];
    int          g_first, g_runtime, g_handoff;
    logic [29:0] ref_adr[NW];
    logic [31:0] ref_dat[NW];

    task automatic run_full(input int poke);
        int   s, fall, nrise, d;
        logic prev, poked;
        log_adr.delete(); log_dat.delete();
        @(negedge clk); #2; s = cyc_n; start = 1'b1;
        @(negedge clk); #2; start = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_done_clr", done, 0);
        chk("start_err_clr", error, 0);
        prev = wb_cyc; poked = 0; fall = -1; nrise = 0; d = -1; g_first = -1;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk); #2;
            if (poke >= 0 && !poked && busy && step == 6'(poke)) begin
                poked = 1; start = 1'b1;
                @(negedge clk); #2; start = 1'b0;
                prev = wb_cyc;
                continue;
            end
            if (wb_cyc && !prev) begin
                if (nrise == 0) g_first = cyc_n - s;
                else if (nrise < 30) g_gap[nrise] = cyc_n - fall;
                nrise++;
            end
            if (!wb_cyc && prev) fall = cyc_n;
            prev = wb_cyc;
            if (done || error) begin d = cyc_n; break; end
        end
        if (d < 0) chk("run_bound_expired", 0, 1);
        g_runtime = d - s;
        g_handoff = d - fall;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_error", error, 0);
        chk("log_count", log_adr.size(), NW);
    endtask

    initial begin
        int cnt, found;
        build_script();
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk); #2;
        chk("rst_cyc", wb_cyc, 0); chk("rst_stb", wb_stb, 0); chk("rst_we", wb_we, 0);
        chk("rst_sel", wb_sel, 0); chk("rst_adr", wb_adr, 0); chk("rst_dat", wb_dat_w, 0);
        chk("rst_busy", busy, 0); chk("rst_done", done, 0); chk("rst_err", error, 0);
        chk("rst_step", step, 0);

        // Zero-wait slave: literal timing and log contents.
        slave_mode = 0;
        run_full(-1);
        chk("first_rise_latency", g_first, 2);
        chk("runtime_zero_wait", g_runtime, 1489);
        if (log_adr.size() == NW) begin
            chk("log4_adr", log_adr[4], 30'h2403);  chk("log4_dat", log_dat[4], 32'h200);
            chk("log28_adr", log_adr[28], 30'h2400); chk("log28_dat", log_dat[28], 32'h01);
            chk("log9_adr", log_adr[9], 30'h2404);  chk("log9_dat", log_dat[9], 32'h3);
            for (int i = 0; i < NW; i++) begin ref_adr[i] = log_adr[i]; ref_dat[i] = log_dat[i]; end
        end else begin
            for (int i = 0; i < NW; i++) begin ref_adr[i] = exp_adr[i]; ref_dat[i] = exp_dat[i]; end
        end

        // Random wait states: same log, delay gaps.
        slave_mode = 1;
        run_full(-1);
        chk("gap_dllk", g_gap[24], W_DLLK + 1);
        chk("gap_zq", g_gap[28], W_ZQ + 1);
        chk("gap_handoff", g_handoff, W_HO + 1);
        if (log_adr.size() == NW) begin
            cnt = 0;
            for (int i = 0; i < NW; i++)
                if (log_adr[i] !== ref_adr[i] || log_dat[i] !== ref_dat[i]) cnt++;
            chk("random_log_same", cnt, 0);
        end

        // Stuck slave at write 6.
        slave_mode = 2; stuck_idx = 6;
        log_adr.delete(); log_dat.delete();
        @(negedge clk); #2 start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        cnt = 0; found = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #2;
            if (wb_cyc && step == 6'd6) cnt++;
            if (error) begin found = 1; break; end
        end
        chk("timeout_reached", found, 1);
        chk("timeout_cyc_cycles", cnt, TO);
        chk("timeout_error", error, 1);
        chk("timeout_step", step, 6);
        chk("timeout_busy", busy, 0);
        chk("timeout_cyc_low", wb_cyc, 0);
        slave_mode = 1;
        run_full(-1);

        // Reset mid-transfer at step 10.
        log_adr.delete(); log_dat.delete();
        @(negedge clk); #2 start = 1'b1;
        @(negedge clk); #2 start = 1'b0;
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #2;
            if (wb_cyc && step == 6'd10) begin found = 1; break; end
        end
        chk("reach_step10", found, 1);
        rst = 1'b1;
        @(negedge clk); #2 rst = 1'b0;
        chk("mid_rst_cyc", wb_cyc, 0); chk("mid_rst_busy", busy, 0);
        chk("mid_rst_step", step, 0);  chk("mid_rst_adr", wb_adr, 0);
        chk("mid_rst_dat", wb_dat_w, 0); chk("mid_rst_sel", wb_sel, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk); #2;
            if (wb_cyc) cnt++;
        end
        chk("no_bus_after_rst", cnt, 0);
        chk("log_after_rst", log_adr.size(), 10);

        // start while busy at step 12, then start again from DONE.
        run_full(12);
        run_full(-1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
